// File: rtl/corrector_hamming_if.sv
// Bus bundle for the SECDED corrector: received word in, decoded result and
// error statistics out, with a valid/ready style handshake on each side.
interface corrector_hamming_if;
  logic [7:0] palabra_rx;
  logic       valido_in;
  logic       listo_out;
  logic [3:0] dato;
  logic [3:0] sindrome;
  logic       error_simple;
  logic       error_doble;
  logic       valido_out;
  logic       ack_in;
  logic [7:0] cuenta_simple;
  logic [7:0] cuenta_doble;

  // slave: the corrector itself
  modport slave (
    input  palabra_rx, valido_in, ack_in,
    output listo_out, dato, sindrome, error_simple, error_doble,
           valido_out, cuenta_simple, cuenta_doble
  );

  // master: the producer/consumer environment around the corrector
  modport master (
    output palabra_rx, valido_in, ack_in,
    input  listo_out, dato, sindrome, error_simple, error_doble,
           valido_out, cuenta_simple, cuenta_doble
  );
endinterface

// File: rtl/corrector_hamming.sv
// SECDED Hamming(8,4) corrector: registers a received word, computes syndrome
// and overall parity, corrects single errors, flags doubles, keeps error counts.
module corrector_hamming (
  input  logic                  clk,
  input  logic                  rst,
  corrector_hamming_if.slave    bus
);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    CALCULO = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t estado, estado_sig;

  logic [7:0] r;
  logic [2:0] s;
  logic       gp;
  logic [7:0] r_corr;
  logic       clase_simple;
  logic       clase_doble;

  logic [3:0] dato_q;
  logic [3:0] sindrome_q;
  logic       error_simple_q;
  logic       error_doble_q;
  logic [7:0] cuenta_simple_q;
  logic [7:0] cuenta_doble_q;
  logic       listo;
  logic       valido;

  // State register
  always_ff @(posedge clk) begin
    if (rst) estado <= ESPERA;
    else     estado <= estado_sig;
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      ESPERA:  if (bus.valido_in) estado_sig = CALCULO;
      CALCULO: estado_sig = ENTREGA;
      ENTREGA: if (bus.ack_in) estado_sig = ESPERA;
      default: estado_sig = ESPERA;
    endcase
  end

  // Handshake outputs are pure functions of the state
  always_comb begin
    listo  = 1'b0;
    valido = 1'b0;
    unique case (estado)
      ESPERA:  listo  = 1'b1;
      ENTREGA: valido = 1'b1;
      default: ;
    endcase
  end

  // Syndrome over positions 1..7 (r0..r6); bit 7 is the overall parity bit g0
  always_comb begin
    s[0] = r[0] ^ r[2] ^ r[4] ^ r[6];
    s[1] = r[1] ^ r[2] ^ r[5] ^ r[6];
    s[2] = r[3] ^ r[4] ^ r[5] ^ r[6];
    gp   = ^r;
  end

  // A non-zero syndrome with odd overall parity points at the flipped bit
  always_comb begin
    r_corr = r;
    if (gp && (s != 3'd0)) r_corr[s - 3'd1] = ~r[s - 3'd1];
  end

  assign clase_simple = gp;
  assign clase_doble  = !gp && (s != 3'd0);

  // Datapath: capture word, then latch result and update counters in CALCULO
  always_ff @(posedge clk) begin
    if (rst) begin
      r               <= '0;
      dato_q          <= '0;
      sindrome_q      <= '0;
      error_simple_q  <= 1'b0;
      error_doble_q   <= 1'b0;
      cuenta_simple_q <= '0;
      cuenta_doble_q  <= '0;
    end else begin
      if (estado == ESPERA && bus.valido_in) r <= bus.palabra_rx;
      if (estado == CALCULO) begin
        dato_q         <= {r_corr[2], r_corr[4], r_corr[5], r_corr[6]};
        sindrome_q     <= {gp, s};
        error_simple_q <= clase_simple;
        error_doble_q  <= clase_doble;
        if (clase_simple && (cuenta_simple_q != '1))
          cuenta_simple_q <= cuenta_simple_q + 8'd1;
        if (clase_doble && (cuenta_doble_q != '1))
          cuenta_doble_q <= cuenta_doble_q + 8'd1;
      end
    end
  end

  assign bus.listo_out     = listo;
  assign bus.valido_out    = valido;
  assign bus.dato          = dato_q;
  assign bus.sindrome      = sindrome_q;
  assign bus.error_simple  = error_simple_q;
  assign bus.error_doble   = error_doble_q;
  assign bus.cuenta_simple = cuenta_simple_q;
  assign bus.cuenta_doble  = cuenta_doble_q;

  a_flags_exclusivos: assert property (
    @(posedge clk) !(error_simple_q && error_doble_q)
  );

  a_handshake_exclusivo: assert property (
    @(posedge clk) !(listo && valido)
  );

endmodule

// File: tb/tb_corrector_hamming.sv
// Self-checking bench for corrector_hamming: directed SECDED cases, random
// words with random backpressure, counter saturation and reset mid-flight.
module tb_corrector_hamming;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  corrector_hamming_if bus();

  corrector_hamming dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pruebas = 0;
  int fallos  = 0;
  int cnt_s   = 0;
  int cnt_d   = 0;
  logic [3:0] ult_dato = '0;
  logic [3:0] ult_sind = '0;
  logic       ult_es   = 1'b0;
  logic       ult_ed   = 1'b0;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    pruebas++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  // Reference: syndrome as XOR of the 1-based positions of all set bits
  function automatic void modelo(input logic [7:0] w, output logic [3:0] d,
                                 output logic [3:0] sd, output logic es, output logic ed);
    int sin;
    logic par;
    logic [7:0] c;
    sin = 0;
    for (int i = 0; i < 7; i++) if (w[i]) sin = sin ^ (i + 1);
    par = ($countones(w) % 2) == 1;
    c = w;
    if (par && sin != 0) c[sin - 1] = ~c[sin - 1];
    d  = {c[2], c[4], c[5], c[6]};
    sd = {par, 3'(sin)};
    es = par;
    ed = !par && (sin != 0);
  endfunction

  task automatic chequear_salidas(input string tag);
    chequear({tag, "_dato"}, 32'(bus.dato), 32'(ult_dato));
    chequear({tag, "_sind"}, 32'(bus.sindrome), 32'(ult_sind));
    chequear({tag, "_es"}, 32'(bus.error_simple), 32'(ult_es));
    chequear({tag, "_ed"}, 32'(bus.error_doble), 32'(ult_ed));
    chequear({tag, "_cs"}, 32'(bus.cuenta_simple), 32'(cnt_s));
    chequear({tag, "_cd"}, 32'(bus.cuenta_doble), 32'(cnt_d));
  endtask

  task automatic enviar(input logic [7:0] w, input int espera, input bit presion);
    logic [3:0] d, sd;
    logic es, ed;
    int n;
    modelo(w, d, sd, es, ed);
    n = 0;
    while (!bus.listo_out && n < 20) begin
      ciclo();
      n++;
    end
    chequear("listo_espera", 32'(bus.listo_out), 32'd1);
    bus.palabra_rx = w;
    bus.valido_in  = 1'b1;
    ciclo();
    bus.valido_in = presion;
    if (presion) bus.palabra_rx = 8'($urandom);
    chequear("calc_listo", 32'(bus.listo_out), 32'd0);
    chequear("calc_valido", 32'(bus.valido_out), 32'd0);
    chequear_salidas("calc_retenido");
    ciclo();
    if (es && cnt_s < 255) cnt_s++;
    if (ed && cnt_d < 255) cnt_d++;
    ult_dato = d;
    ult_sind = sd;
    ult_es   = es;
    ult_ed   = ed;
    chequear("ent_valido", 32'(bus.valido_out), 32'd1);
    chequear_salidas("ent");
    for (int k = 0; k < espera; k++) begin
      bus.ack_in = 1'b0;
      if (presion) bus.palabra_rx = 8'($urandom);
      ciclo();
      chequear("bp_valido", 32'(bus.valido_out), 32'd1);
      chequear("bp_listo", 32'(bus.listo_out), 32'd0);
      chequear_salidas("bp");
    end
    bus.ack_in = 1'b1;
    ciclo();
    bus.ack_in    = 1'b0;
    bus.valido_in = 1'b0;
    chequear("ack_valido", 32'(bus.valido_out), 32'd0);
    chequear("ack_listo", 32'(bus.listo_out), 32'd1);
    chequear_salidas("ack_retenido");
  endtask

  initial begin
    logic [7:0] w;
    rst            = 1'b1;
    bus.palabra_rx = '0;
    bus.valido_in  = 1'b0;
    bus.ack_in     = 1'b0;
    ciclo();
    ciclo();
    rst = 1'b0;
    chequear("rst_listo", 32'(bus.listo_out), 32'd1);
    chequear("rst_valido", 32'(bus.valido_out), 32'd0);
    chequear_salidas("rst");

    enviar(8'h66, 0, 1'b0);
    chequear("limpia_dato", 32'(bus.dato), 32'hB);
    chequear("limpia_sind", 32'(bus.sindrome), 32'h0);
    chequear("limpia_cs", 32'(bus.cuenta_simple), 32'd0);

    enviar(8'h76, 0, 1'b0);
    chequear("simple_dato", 32'(bus.dato), 32'hB);
    chequear("simple_sind", 32'(bus.sindrome), 32'hD);
    chequear("simple_es", 32'(bus.error_simple), 32'd1);
    chequear("simple_cs", 32'(bus.cuenta_simple), 32'd1);

    enviar(8'hE6, 1, 1'b0);
    chequear("g0_dato", 32'(bus.dato), 32'hB);
    chequear("g0_sind", 32'(bus.sindrome), 32'h8);
    chequear("g0_es", 32'(bus.error_simple), 32'd1);

    enviar(8'h65, 0, 1'b0);
    chequear("doble_dato", 32'(bus.dato), 32'hB);
    chequear("doble_sind", 32'(bus.sindrome), 32'h3);
    chequear("doble_ed", 32'(bus.error_doble), 32'd1);
    chequear("doble_es", 32'(bus.error_simple), 32'd0);
    chequear("doble_cd", 32'(bus.cuenta_doble), 32'd1);

    // Held-off consumer while the producer keeps offering new words
    enviar(8'h76, 5, 1'b1);

    for (int i = 0; i < 40; i++)
      enviar(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Odd overall parity always classifies as a single error
    for (int i = 0; i < 300; i++) begin
      w = 8'($urandom);
      if (($countones(w) % 2) == 0) w[7] = ~w[7];
      enviar(w, 0, 1'b0);
    end
    chequear("sat_cs", 32'(bus.cuenta_simple), 32'hFF);

    // Reset while a word is in CALCULO, with valido_in still asserted
    bus.palabra_rx = 8'h65;
    bus.valido_in  = 1'b1;
    ciclo();
    chequear("pre_rst_listo", 32'(bus.listo_out), 32'd0);
    rst = 1'b1;
    ciclo();
    rst           = 1'b0;
    bus.valido_in = 1'b0;
    cnt_s    = 0;
    cnt_d    = 0;
    ult_dato = '0;
    ult_sind = '0;
    ult_es   = 1'b0;
    ult_ed   = 1'b0;
    chequear("rst2_listo", 32'(bus.listo_out), 32'd1);
    chequear("rst2_valido", 32'(bus.valido_out), 32'd0);
    chequear_salidas("rst2");
    for (int k = 0; k < 4; k++) begin
      ciclo();
      chequear("descartada_valido", 32'(bus.valido_out), 32'd0);
      chequear_salidas("descartada");
    end

    $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
